// File: rtl/pe_job_scheduler.sv
// Two-requester round-robin job scheduler in front of a vector PE array.
// One job in flight; illegal opcodes and PE timeouts return an error response.
module pe_job_scheduler #(
  parameter int DATA_LEN      = 32,
  parameter int PE_ELEMENTS   = 4,
  parameter int PE_OPCODE_LEN = 3,
  parameter int TIMEOUT       = 64
) (
  input  logic                                      clk,
  input  logic                                      rstn,
  input  logic [1:0]                                req_valid,
  output logic [1:0]                                req_ready,
  input  logic [1:0][PE_OPCODE_LEN-1:0]             req_opcode,
  input  logic [1:0][PE_ELEMENTS-1:0][DATA_LEN-1:0] req_data_a,
  input  logic [1:0][PE_ELEMENTS-1:0][DATA_LEN-1:0] req_data_b,
  output logic                                      pe_start,
  output logic [PE_OPCODE_LEN-1:0]                  pe_opcode,
  output logic [PE_ELEMENTS-1:0][DATA_LEN-1:0]      pe_data_a,
  output logic [PE_ELEMENTS-1:0][DATA_LEN-1:0]      pe_data_b,
  input  logic                                      pe_done,
  input  logic [PE_ELEMENTS-1:0][DATA_LEN-1:0]      pe_result,
  output logic                                      rsp_valid,
  input  logic                                      rsp_ready,
  output logic                                      rsp_id,
  output logic [PE_ELEMENTS-1:0][DATA_LEN-1:0]      rsp_data,
  output logic                                      rsp_error,
  output logic                                      busy
);
  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_t;

  state_t                                 state_q, state_d;
  logic [TW-1:0]                          timer_q, timer_d;
  logic                                   last_q, last_d;
  logic [PE_OPCODE_LEN-1:0]               op_q, op_d;
  logic [PE_ELEMENTS-1:0][DATA_LEN-1:0]   a_q, a_d, b_q, b_d, rdata_q, rdata_d;
  logic                                   rid_q, rid_d, rerr_q, rerr_d;
  logic [1:0]                             grant_s;
  logic                                   gidx_s, accept_s, legal_s, tmo_s;

  function automatic logic op_legal(input logic [PE_OPCODE_LEN-1:0] op);
    return (op >= PE_OPCODE_LEN'(1)) && (op <= PE_OPCODE_LEN'(4));
  endfunction

  // Round-robin grant; gated by rstn so req_ready is low while reset is asserted.
  always_comb begin
    grant_s = 2'b00;
    gidx_s  = 1'b0;
    if ((state_q == IDLE) && rstn) begin
      if (req_valid == 2'b11) begin
        gidx_s  = ~last_q;
        grant_s = last_q ? 2'b01 : 2'b10;
      end else if (req_valid[0]) begin
        gidx_s  = 1'b0;
        grant_s = 2'b01;
      end else if (req_valid[1]) begin
        gidx_s  = 1'b1;
        grant_s = 2'b10;
      end else begin
        grant_s = 2'b00;
      end
    end else begin
      grant_s = 2'b00;
    end
    accept_s = |grant_s;
    legal_s  = op_legal(req_opcode[gidx_s]);
    tmo_s    = (timer_q == TW'(TIMEOUT - 2));
  end

  // Next-state logic; a pe_done in the final WAIT cycle still lands as a normal result.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept_s) state_d = legal_s ? ISSUE : RESP;
               else          state_d = IDLE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (pe_done || tmo_s) state_d = RESP;
               else                  state_d = WAIT;
      RESP:    if (rsp_ready) state_d = IDLE;
               else           state_d = RESP;
      default: state_d = IDLE;
    endcase
  end

  // Job latch, wait timer and response capture.
  always_comb begin
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    rid_d   = rid_q;
    rerr_d  = rerr_q;
    rdata_d = rdata_q;
    last_d  = last_q;
    timer_d = timer_q;
    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (accept_s) begin
          op_d    = req_opcode[gidx_s];
          a_d     = req_data_a[gidx_s];
          b_d     = req_data_b[gidx_s];
          rid_d   = gidx_s;
          last_d  = gidx_s;
          rerr_d  = ~legal_s;
          rdata_d = '0;
        end else begin
          rerr_d  = rerr_q;
        end
      end
      ISSUE: timer_d = '0;
      WAIT: begin
        timer_d = timer_q + TW'(1);
        if (pe_done) begin
          rdata_d = pe_result;
          rerr_d  = 1'b0;
        end else if (tmo_s) begin
          rdata_d = '0;
          rerr_d  = 1'b1;
        end else begin
          rdata_d = rdata_q;
        end
      end
      RESP:    timer_d = timer_q;
      default: timer_d = '0;
    endcase
  end

  // Output decode from registered state and job latch.
  always_comb begin
    req_ready = grant_s;
    pe_start  = (state_q == ISSUE);
    rsp_valid = (state_q == RESP);
    busy      = (state_q != IDLE);
    pe_opcode = op_q;
    pe_data_a = a_q;
    pe_data_b = b_q;
    rsp_id    = rid_q;
    rsp_data  = rdata_q;
    rsp_error = rerr_q;
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      timer_q <= '0;
      last_q  <= 1'b1;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      rid_q   <= 1'b0;
      rerr_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      last_q  <= last_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rid_q   <= rid_d;
      rerr_q  <= rerr_d;
      rdata_q <= rdata_d;
    end
  end
endmodule

// File: tb/tb_pe_job_scheduler.sv
// Directed bench for pe_job_scheduler; the bench plays both requesters and the PE array.
module tb_pe_job_scheduler;
  localparam int DL = 32;
  localparam int PE = 4;
  localparam int OL = 3;
  localparam int TO = 8;

  logic                      clk = 1'b0;
  logic                      rstn;
  logic [1:0]                req_valid;
  logic [1:0]                req_ready;
  logic [1:0][OL-1:0]        req_opcode;
  logic [1:0][PE-1:0][DL-1:0] req_data_a, req_data_b;
  logic                      pe_start;
  logic [OL-1:0]             pe_opcode;
  logic [PE-1:0][DL-1:0]     pe_data_a, pe_data_b, pe_result, rsp_data;
  logic                      pe_done, rsp_valid, rsp_ready, rsp_id, rsp_error, busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pe_job_scheduler #(.DATA_LEN(DL), .PE_ELEMENTS(PE), .PE_OPCODE_LEN(OL), .TIMEOUT(TO)) dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready),
    .req_opcode(req_opcode), .req_data_a(req_data_a), .req_data_b(req_data_b),
    .pe_start(pe_start), .pe_opcode(pe_opcode), .pe_data_a(pe_data_a), .pe_data_b(pe_data_b),
    .pe_done(pe_done), .pe_result(pe_result), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_error(rsp_error), .busy(busy)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] vec(input int e0, input int e1, input int e2, input int e3);
    return {32'(e3), 32'(e2), 32'(e1), 32'(e0)};
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] res;
    rstn       = 1'b0;
    req_valid  = 2'b01;
    req_opcode = '0;
    req_data_a = '0;
    req_data_b = '0;
    pe_done    = 1'b0;
    pe_result  = '0;
    rsp_ready  = 1'b1;
    #2;
    check("rst_req_ready", req_ready, 2'b00);
    check("rst_busy", busy, 1'b0);
    check("rst_pe_start", pe_start, 1'b0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_pe_opcode", pe_opcode, 3'd0);
    check("rst_pe_data_a", pe_data_a, 128'd0);

    // Single ADD job from requester 0, released together with reset.
    tick();
    rstn          = 1'b1;
    req_opcode[0] = 3'd1;
    req_data_a[0] = vec(1, 2, 3, 4);
    req_data_b[0] = vec(5, 6, 7, 8);
    #1 check("single_grant", req_ready, 2'b01);
    tick();
    req_valid = 2'b00;
    check("single_pe_start", pe_start, 1'b1);
    check("single_busy", busy, 1'b1);
    check("single_pe_opcode", pe_opcode, 3'd1);
    check("single_pe_data_a", pe_data_a, vec(1, 2, 3, 4));
    check("single_pe_data_b", pe_data_b, vec(5, 6, 7, 8));
    check("single_req_ready", req_ready, 2'b00);
    tick();
    check("single_start_1cyc", pe_start, 1'b0);
    check("single_opcode_hold", pe_opcode, 3'd1);
    tick();
    tick();
    pe_done   = 1'b1;
    pe_result = vec(6, 8, 10, 12);
    check("single_no_early_rsp", rsp_valid, 1'b0);
    tick();
    pe_done = 1'b0;
    check("single_rsp_valid", rsp_valid, 1'b1);
    check("single_rsp_id", rsp_id, 1'b0);
    check("single_rsp_data", rsp_data, vec(6, 8, 10, 12));
    check("single_rsp_error", rsp_error, 1'b0);
    tick();
    check("single_idle_valid", rsp_valid, 1'b0);
    check("single_idle_busy", busy, 1'b0);

    // Stray pe_done in IDLE must not produce anything.
    pe_done = 1'b1;
    tick();
    pe_done = 1'b0;
    check("stray_done_busy", busy, 1'b0);
    check("stray_done_valid", rsp_valid, 1'b0);

    // Illegal opcode 6 from requester 1, then 5 cycles of backpressure.
    req_valid     = 2'b10;
    req_opcode[1] = 3'd6;
    rsp_ready     = 1'b0;
    #1 check("illegal_grant", req_ready, 2'b10);
    tick();
    check("illegal_no_start", pe_start, 1'b0);
    req_valid     = 2'b11;
    req_opcode[1] = 3'd2;
    req_data_a[1] = vec(9, 9, 9, 9);
    for (int k = 0; k < 5; k++) begin
      #1;
      check("bp_rsp_valid", rsp_valid, 1'b1);
      check("bp_rsp_id", rsp_id, 1'b1);
      check("bp_rsp_error", rsp_error, 1'b1);
      check("bp_rsp_data", rsp_data, 128'd0);
      check("bp_req_ready", req_ready, 2'b00);
      check("bp_busy", busy, 1'b1);
      tick();
    end
    rsp_ready = 1'b1;
    #1 check("handshake_no_accept", req_ready, 2'b00);
    tick();

    // Contention: both requesters held, grants must alternate 0,1,0,1.
    for (int i = 0; i < 4; i++) begin
      logic g;
      g = (i % 2 == 1);
      #1 check("rr_grant", req_ready, g ? 2'b10 : 2'b01);
      tick();
      check("rr_pe_start", pe_start, 1'b1);
      check("rr_pe_opcode", pe_opcode, g ? 3'd2 : 3'd1);
      check("rr_pe_data_a", pe_data_a, g ? vec(9, 9, 9, 9) : vec(1, 2, 3, 4));
      tick();
      pe_done   = 1'b1;
      res       = vec(10 * i + 1, 10 * i + 2, 10 * i + 3, 10 * i + 4);
      pe_result = res;
      tick();
      pe_done = 1'b0;
      check("rr_rsp_valid", rsp_valid, 1'b1);
      check("rr_rsp_id", rsp_id, g);
      check("rr_rsp_data", rsp_data, res);
      tick();
    end
    req_valid = 2'b00;

    // Timeout: no pe_done, response exactly TIMEOUT cycles after pe_start.
    tick();
    req_valid     = 2'b01;
    req_opcode[0] = 3'd3;
    #1 check("tmo_grant", req_ready, 2'b01);
    tick();
    req_valid = 2'b00;
    check("tmo_pe_start", pe_start, 1'b1);
    for (int k = 1; k <= TO; k++) begin
      tick();
      check("tmo_rsp_timing", rsp_valid, (k == TO));
    end
    check("tmo_rsp_error", rsp_error, 1'b1);
    check("tmo_rsp_data", rsp_data, 128'd0);
    tick();

    // pe_done in the final WAIT cycle beats the timeout.
    req_valid     = 2'b01;
    req_opcode[0] = 3'd4;
    tick();
    req_valid = 2'b00;
    check("late_pe_start", pe_start, 1'b1);
    for (int k = 1; k < TO; k++) tick();
    check("late_still_wait", rsp_valid, 1'b0);
    pe_done   = 1'b1;
    pe_result = vec(70, 80, 90, 100);
    tick();
    pe_done = 1'b0;
    check("late_rsp_valid", rsp_valid, 1'b1);
    check("late_rsp_error", rsp_error, 1'b0);
    check("late_rsp_data", rsp_data, vec(70, 80, 90, 100));
    tick();

    // Reset while waiting on the PE discards the job.
    req_valid     = 2'b01;
    req_opcode[0] = 3'd1;
    tick();
    req_valid = 2'b00;
    tick();
    check("rstwait_busy_before", busy, 1'b1);
    #2 rstn = 1'b0;
    #1;
    check("rstwait_busy", busy, 1'b0);
    check("rstwait_pe_opcode", pe_opcode, 3'd0);
    check("rstwait_pe_data_a", pe_data_a, 128'd0);
    check("rstwait_rsp_valid", rsp_valid, 1'b0);
    check("rstwait_rsp_error", rsp_error, 1'b0);
    tick();
    rstn    = 1'b1;
    pe_done = 1'b1;
    tick();
    pe_done = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("rstwait_no_rsp", rsp_valid, 1'b0);
      check("rstwait_idle", busy, 1'b0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
